// File: rtl/param_fir_engine.sv
// Multi-channel FIR engine: LANES MACs per cycle over a shared coefficient set,
// per-channel circular sample histories, shift-and-saturate output stage.
module param_fir_engine #(
   parameter int  IN_WIDTH   = 16,
   parameter int  COEF_WIDTH = 16,
   parameter int  TAPS       = 64,
   parameter int  LANES      = 4,
   parameter int  CHANNELS   = 2,
   parameter int  OUT_WIDTH  = 32,
   parameter int  SHIFT      = 0,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int A_W        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                  clkIn,
   input  logic                  nResetIn,
   input  logic                  startIn,
   input  logic [CH_W-1:0]       channelIn,
   input  logic [IN_WIDTH-1:0]   sampleIn,
   input  logic                  coefWrIn,
   input  logic [A_W-1:0]        coefAddrIn,
   input  logic [COEF_WIDTH-1:0] coefDataIn,
   output logic                  busyOut,
   output logic                  doneOut,
   output logic [CH_W-1:0]       channelOut,
   output logic [OUT_WIDTH-1:0]  dataOut
);

   localparam int PROD_W  = IN_WIDTH + COEF_WIDTH;
   localparam int ACC_W   = PROD_W + $clog2(TAPS);
   localparam int EXT_W   = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
   localparam int STEPS   = TAPS / LANES;
   localparam int HIST_N  = CHANNELS * TAPS;
   localparam int HIST_AW = (HIST_N > 1) ? $clog2(HIST_N) : 1;
   localparam int HIST_SZ = 1 << HIST_AW;
   localparam int COEF_SZ = 1 << A_W;
   localparam int CH_SZ   = 1 << CH_W;
   localparam int CNT_W   = ($clog2(HIST_N + 1) > 2) ? $clog2(HIST_N + 1) : 2;

   typedef enum logic [2:0] {INIT, IDLE, RUN, DRAIN, DONE} state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [CH_W-1:0]               run_ch_q, run_ch_d;
   logic [A_W-1:0]                wp_q [CH_SZ];
   logic [A_W-1:0]                wp_d [CH_SZ];
   logic [A_W-1:0]                wp_next;
   logic                          done_q, done_d;
   logic [CH_W-1:0]               chan_out_q, chan_out_d;
   logic signed [OUT_WIDTH-1:0]   data_out_q, data_out_d;

   logic signed [IN_WIDTH-1:0]    hist_q [HIST_SZ];
   logic signed [IN_WIDTH-1:0]    hist_d [HIST_SZ];
   logic signed [COEF_WIDTH-1:0]  coef_q [COEF_SZ];
   logic signed [COEF_WIDTH-1:0]  coef_d [COEF_SZ];

   logic signed [IN_WIDTH-1:0]    tap_x [LANES];
   logic signed [COEF_WIDTH-1:0]  tap_c [LANES];
   logic signed [PROD_W-1:0]      prod_p0_q [LANES];
   logic signed [PROD_W-1:0]      prod_p0_d [LANES];
   logic                          vld_p0_q, vld_p0_d;
   logic signed [ACC_W-1:0]       sum_p1_q, sum_p1_d;
   logic                          vld_p1_q, vld_p1_d;
   logic signed [ACC_W-1:0]       acc_p2_q, acc_p2_d;

   logic                          idle_like;
   logic                          ch_ok;
   logic                          addr_ok;
   logic                          accept;

   // Flat history address of the sample 'back' positions older than slot 'pos'.
   function automatic logic [HIST_AW-1:0] hist_addr(input logic [CH_W-1:0] ch,
                                                   input logic [A_W-1:0]  pos,
                                                   input int              back);
      int p;
      p = int'(pos) - back;
      if (p < 0) p = p + TAPS;
      return HIST_AW'(int'(ch) * TAPS + p);
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
      logic signed [EXT_W-1:0] v;
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      v  = EXT_W'(a) >>> SHIFT;
      hi = {{(EXT_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
      lo = ~hi;
      if (v > hi)      return hi[OUT_WIDTH-1:0];
      else if (v < lo) return lo[OUT_WIDTH-1:0];
      else             return v[OUT_WIDTH-1:0];
   endfunction

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign ch_ok     = {1'b0, channelIn} < (CH_W + 1)'(CHANNELS);
   assign addr_ok   = {1'b0, coefAddrIn} < (A_W + 1)'(TAPS);
   assign accept    = idle_like && startIn && ch_ok;
   assign wp_next   = (wp_q[channelIn] == A_W'(TAPS - 1)) ? '0 : wp_q[channelIn] + A_W'(1);

   assign busyOut    = !idle_like;
   assign doneOut    = done_q;
   assign channelOut = chan_out_q;
   assign dataOut    = data_out_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      run_ch_d   = run_ch_q;
      wp_d       = wp_q;
      hist_d     = hist_q;
      coef_d     = coef_q;
      done_d     = 1'b0;
      chan_out_d = chan_out_q;
      data_out_d = data_out_q;
      case (state_q)
         INIT: begin
            hist_d[HIST_AW'(cnt_q)] = '0;
            if (cnt_q < CNT_W'(TAPS)) coef_d[A_W'(cnt_q)] = '0;
            if (cnt_q == CNT_W'(HIST_N - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE, DONE: begin
            // The write lands at this edge, so a same-cycle start already sees it.
            if (coefWrIn && addr_ok) coef_d[coefAddrIn] = coefDataIn;
            if (accept) begin
               wp_d[channelIn]                          = wp_next;
               hist_d[hist_addr(channelIn, wp_next, 0)] = sampleIn;
               run_ch_d                                 = channelIn;
               cnt_d                                    = '0;
               state_d                                  = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(2)) begin
               cnt_d      = '0;
               state_d    = DONE;
               done_d     = 1'b1;
               chan_out_d = run_ch_q;
               data_out_d = sat_shift(acc_p2_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         tap_x[l] = hist_q[hist_addr(run_ch_q, wp_q[run_ch_q], int'(cnt_q) * LANES + l)];
         tap_c[l] = coef_q[A_W'(int'(cnt_q) * LANES + l)];
      end
   end

   // Stage p0: full-precision lane products
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         prod_p0_d[l] = PROD_W'(tap_x[l]) * PROD_W'(tap_c[l]);
      end
      vld_p0_d = (state_q == RUN);
   end

   // Stage p1: lane adder tree
   always_comb begin
      sum_p1_d = '0;
      for (int l = 0; l < LANES; l++) begin
         sum_p1_d = sum_p1_d + ACC_W'(prod_p0_q[l]);
      end
      vld_p1_d = vld_p0_q;
   end

   // Stage p2: accumulator, cleared when a new sample is accepted
   always_comb begin
      acc_p2_d = acc_p2_q;
      if (accept)        acc_p2_d = '0;
      else if (vld_p1_q) acc_p2_d = acc_p2_q + sum_p1_q;
   end

   always_ff @(posedge clkIn or negedge nResetIn) begin
      if (!nResetIn) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         run_ch_q   <= '0;
         wp_q       <= '{default: '0};
         vld_p0_q   <= 1'b0;
         vld_p1_q   <= 1'b0;
         done_q     <= 1'b0;
         chan_out_q <= '0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         run_ch_q   <= run_ch_d;
         wp_q       <= wp_d;
         vld_p0_q   <= vld_p0_d;
         vld_p1_q   <= vld_p1_d;
         done_q     <= done_d;
         chan_out_q <= chan_out_d;
         data_out_q <= data_out_d;
      end
   end

   always_ff @(posedge clkIn) begin
      hist_q    <= hist_d;
      coef_q    <= coef_d;
      prod_p0_q <= prod_p0_d;
      sum_p1_q  <= sum_p1_d;
      acc_p2_q  <= acc_p2_d;
   end

endmodule
